// File: rtl/stream_pkg.sv
// Shared types and width helpers for the store-and-forward packet buffer.
package stream_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int DEPTH_DEF    = 256;
  localparam int MAX_PKTS_DEF = 8;
  localparam int MAX_LEN_DEF  = 256;

  localparam int PTR_W = $clog2(DEPTH_DEF) + 1;
  localparam int LEN_W = $clog2(MAX_LEN_DEF);
  localparam int PKT_W = $clog2(MAX_PKTS_DEF) + 1;

  typedef enum logic {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } state_t;

endpackage

// File: rtl/packet_fifo_if.sv
// Stream-in / stream-out bundle of the packet buffer plus its status and error flags.
// Handshake: a beat moves on a rising clk edge iff valid && ready; valid never waits on ready.
interface packet_fifo_if #(
  parameter int DATA_W = stream_pkg::DATA_W_DEF,
  parameter int LEN_W  = stream_pkg::LEN_W,
  parameter int PKT_W  = stream_pkg::PKT_W
);
  logic [DATA_W-1:0] i_stream;
  logic              i_valid;
  logic              i_ready;
  logic              i_last;
  logic              i_drop;
  logic [DATA_W-1:0] o_stream;
  logic              o_valid;
  logic              o_ready;
  logic              o_last;
  logic [LEN_W-1:0]  o_len;
  logic [PKT_W-1:0]  pkt_count;
  logic              err_too_long;
  logic              err_dropped;
  logic              clear_errors;

  modport slave (
    input  i_stream, i_valid, i_last, i_drop, o_ready, clear_errors,
    output i_ready, o_stream, o_valid, o_last, o_len, pkt_count,
           err_too_long, err_dropped
  );

  modport master (
    output i_stream, i_valid, i_last, i_drop, o_ready, clear_errors,
    input  i_ready, o_stream, o_valid, o_last, o_len, pkt_count,
           err_too_long, err_dropped
  );
endinterface

// File: rtl/pkt_len_fifo.sv
// Small synchronous FIFO holding committed packet lengths; head is visible without a pop.
module pkt_len_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr, rd;

  assign empty = (wr == rd);
  assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  // Reads as zero when empty so o_len is clean out of reset.
  assign head  = empty ? '0 : mem[rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/packet_fifo.sv
// Store-and-forward packet buffer: packets are written speculatively into a circular
// RAM and become readable only once their last beat commits.
module packet_fifo
  import stream_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_PKTS = MAX_PKTS_DEF,
  parameter int MAX_LEN  = MAX_LEN_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  packet_fifo_if.slave   bus,
  output state_t         dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_LEN);
  localparam int KW = $clog2(MAX_PKTS) + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t         state, state_n;
  logic [PW-1:0]  wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, used;
  logic [LW-1:0]  cnt, cnt_n, rd_cnt, len_head;
  logic [KW-1:0]  pkt_cnt;
  logic           err_long_q, err_drop_q;
  logic           set_long, set_drop, wr_en, commit, pop;
  logic           len_full, len_empty, in_ready, out_valid, out_last;
  logic           i_hs, o_hs;

  assign used      = wr_ptr - rd_ptr;
  assign in_ready  = (state == DISCARD) || ((used != PW'(DEPTH)) && !len_full);
  assign i_hs      = bus.i_valid && in_ready;
  assign out_valid = !len_empty;
  assign out_last  = out_valid && (rd_cnt == len_head);
  assign o_hs      = out_valid && bus.o_ready;
  assign pop       = o_hs && out_last;

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    cnt_n        = cnt;
    wr_en        = 1'b0;
    commit       = 1'b0;
    set_long     = 1'b0;
    set_drop     = 1'b0;
    case (state)
      FILL: begin
        // A drop rewinds to the last commit and outranks both commit and overlength.
        if (bus.i_drop && (cnt != '0 || i_hs)) begin
          wr_ptr_n = commit_ptr;
          cnt_n    = '0;
          set_drop = 1'b1;
          state_n  = (i_hs && bus.i_last) ? FILL : DISCARD;
        end else if (i_hs) begin
          wr_en = 1'b1;
          if (bus.i_last) begin
            commit       = 1'b1;
            wr_ptr_n     = wr_ptr + 1'b1;
            commit_ptr_n = wr_ptr + 1'b1;
            cnt_n        = '0;
          end else if (cnt == LW'(MAX_LEN - 1)) begin
            wr_ptr_n = commit_ptr;
            cnt_n    = '0;
            set_long = 1'b1;
            state_n  = DISCARD;
          end else begin
            wr_ptr_n = wr_ptr + 1'b1;
            cnt_n    = cnt + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (i_hs && bus.i_last) state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.i_stream;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      cnt        <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      pkt_cnt    <= '0;
      err_long_q <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      cnt        <= cnt_n;
      if (o_hs) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= pop ? '0 : rd_cnt + 1'b1;
      end
      case ({commit, pop})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
      // A fresh error event in the same cycle beats the clear.
      if (set_long)              err_long_q <= 1'b1;
      else if (bus.clear_errors) err_long_q <= 1'b0;
      if (set_drop)              err_drop_q <= 1'b1;
      else if (bus.clear_errors) err_drop_q <= 1'b0;
    end
  end

  pkt_len_fifo #(
    .DEPTH (MAX_PKTS),
    .W     (LW)
  ) u_len_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (commit),
    .din   (cnt),
    .pop   (pop),
    .head  (len_head),
    .full  (len_full),
    .empty (len_empty)
  );

  assign bus.i_ready      = in_ready;
  assign bus.o_stream     = mem[rd_ptr[AW-1:0]];
  assign bus.o_valid      = out_valid;
  assign bus.o_last       = out_last;
  assign bus.o_len        = len_head;
  assign bus.pkt_count    = pkt_cnt;
  assign bus.err_too_long = err_long_q;
  assign bus.err_dropped  = err_drop_q;
  assign dbg_state        = state;
endmodule

// File: tb/tb_packet_fifo.sv
// Bench for packet_fifo: directed packets against a queue-based packet model.
module tb_packet_fifo;
  import stream_pkg::*;

  localparam int DEPTH    = 256;
  localparam int MAX_PKTS = 8;
  localparam int MAX_LEN  = 256;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  packet_fifo_if #(.DATA_W(32), .LEN_W(8), .PKT_W(4)) bus ();

  packet_fifo #(
    .DATA_W(32), .DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int max_cnt = 0;

  logic [31:0] exp_q[$];   // committed, unread beats in delivery order
  int          len_q[$];   // committed packet lengths (beats)
  logic [31:0] cur_q[$];   // beats of the packet being received
  int          rd_pos = 0;
  bit          disc = 0;
  bit          e_long = 0, e_drop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return disc || (((DEPTH - exp_q.size() - cur_q.size()) != 0) && (len_q.size() != MAX_PKTS));
  endfunction

  task automatic m_reset();
    exp_q.delete();
    len_q.delete();
    cur_q.delete();
    rd_pos = 0;
    disc   = 0;
    e_long = 0;
    e_drop = 0;
  endtask

  always @(negedge clk) begin
    bit r, v, ihs, ohs, nl, nd;
    int hl;
    if (!rst_n) m_reset();
    r = m_ready();
    v = (len_q.size() != 0);
    chk("i_ready", bus.i_ready, r);
    chk("o_valid", bus.o_valid, v);
    chk("pkt_count", bus.pkt_count, len_q.size());
    chk("err_too_long", bus.err_too_long, e_long);
    chk("err_dropped", bus.err_dropped, e_drop);
    if (v) begin
      hl = len_q[0];
      chk("o_len", bus.o_len, hl - 1);
      chk("o_last", bus.o_last, rd_pos == hl - 1);
      chk("o_stream", bus.o_stream, exp_q[0]);
    end else begin
      chk("o_last_idle", bus.o_last, 0);
    end
    if (int'(bus.pkt_count) > max_cnt) max_cnt = int'(bus.pkt_count);

    if (rst_n) begin
      ihs = bus.i_valid && r;
      ohs = v && bus.o_ready;
      if (ohs) begin
        void'(exp_q.pop_front());
        rd_pos++;
        if (rd_pos == len_q[0]) begin
          void'(len_q.pop_front());
          rd_pos = 0;
        end
      end
      nl = bus.clear_errors ? 1'b0 : e_long;
      nd = bus.clear_errors ? 1'b0 : e_drop;
      if (disc) begin
        if (ihs && bus.i_last) disc = 0;
      end else if (bus.i_drop && (cur_q.size() != 0 || ihs)) begin
        cur_q.delete();
        nd   = 1;
        disc = !(ihs && bus.i_last);
      end else if (ihs) begin
        if (bus.i_last) begin
          foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
          exp_q.push_back(bus.i_stream);
          len_q.push_back(cur_q.size() + 1);
          cur_q.delete();
        end else if (cur_q.size() == MAX_LEN - 1) begin
          cur_q.delete();
          nl   = 1;
          disc = 1;
        end else begin
          cur_q.push_back(bus.i_stream);
        end
      end
      e_long = nl;
      e_drop = nd;
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input bit last, input bit drop);
    int t;
    bus.i_stream = d;
    bus.i_valid  = 1'b1;
    bus.i_last   = last;
    bus.i_drop   = drop;
    t = 0;
    @(negedge clk);
    while (!bus.i_ready && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (t >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: i_ready stuck low for beat %0h", d);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_drop  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input int drop_at);
    for (int i = 0; i < n; i++) beat(base + i, i == n - 1, i == drop_at);
  endtask

  task automatic pulse_clear();
    bus.clear_errors = 1'b1;
    idle(1);
    bus.clear_errors = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n            = 1'b0;
    bus.i_stream     = '0;
    bus.i_valid      = 1'b0;
    bus.i_last       = 1'b0;
    bus.i_drop       = 1'b0;
    bus.o_ready      = 1'b0;
    bus.clear_errors = 1'b0;
    idle(3);
    chk("rst_i_ready", bus.i_ready, 1);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_pkt_count", bus.pkt_count, 0);
    chk("rst_o_len", bus.o_len, 0);
    chk("rst_state", dbg_state, FILL);
    rst_n = 1'b1;
    idle(1);

    // one 4-beat packet held, then drained
    send_pkt(4, 32'hA0, -1);
    @(negedge clk);
    chk("t1_o_valid", bus.o_valid, 1);
    chk("t1_o_len", bus.o_len, 3);
    chk("t1_pkt_count", bus.pkt_count, 1);
    chk("t1_first_beat", bus.o_stream, 32'hA0);
    @(posedge clk); #1;
    bus.o_ready = 1'b1;
    idle(4);
    @(negedge clk);
    chk("t1_drained", bus.pkt_count, 0);

    // back-to-back 3-beat packets with a free-running consumer
    @(posedge clk); #1;
    max_cnt = 0;
    for (int k = 0; k < 6; k++) send_pkt(3, 32'h100 + 16 * k, -1);
    idle(6);
    chk("t2_max_pkt_count_le2", max_cnt <= 2, 1);
    chk("t2_drained", bus.pkt_count, 0);

    // overlength packet swallowed, next packet intact
    send_pkt(MAX_LEN + 3, 32'h1000, -1);
    @(negedge clk);
    chk("t3_err_too_long", bus.err_too_long, 1);
    chk("t3_no_output", bus.o_valid, 0);
    @(posedge clk); #1;
    send_pkt(2, 32'h2000, -1);
    idle(4);
    chk("t3_after_drained", bus.pkt_count, 0);
    pulse_clear();
    @(negedge clk);
    chk("t3_cleared", bus.err_too_long, 0);

    // drop on beat 2 of 5
    @(posedge clk); #1;
    send_pkt(5, 32'h3000, 1);
    @(negedge clk);
    chk("t4_err_dropped", bus.err_dropped, 1);
    chk("t4_no_output", bus.pkt_count, 0);
    @(posedge clk); #1;
    send_pkt(3, 32'h3100, -1);
    idle(5);
    pulse_clear();
    @(negedge clk);
    chk("t4_cleared", bus.err_dropped, 0);

    // length queue full
    @(posedge clk); #1;
    bus.o_ready = 1'b0;
    for (int k = 0; k < MAX_PKTS; k++) send_pkt(1, 32'h40 + k, -1);
    @(negedge clk);
    chk("t5_full_ready", bus.i_ready, 0);
    chk("t5_full_count", bus.pkt_count, 8);
    chk("t5_head_len", bus.o_len, 0);
    @(posedge clk); #1;
    bus.o_ready = 1'b1;
    @(posedge clk); #1;
    bus.o_ready = 1'b0;
    @(negedge clk);
    chk("t5_ready_back", bus.i_ready, 1);
    chk("t5_count_7", bus.pkt_count, 7);
    @(posedge clk); #1;
    bus.o_ready = 1'b1;
    idle(10);

    // asynchronous reset mid-packet and mid-read
    bus.o_ready = 1'b0;
    send_pkt(2, 32'h5000, -1);
    beat(32'h6000, 0, 0);
    beat(32'h6001, 0, 0);
    bus.o_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_o_valid", bus.o_valid, 0);
    chk("t6_rst_i_ready", bus.i_ready, 1);
    chk("t6_rst_pkt_count", bus.pkt_count, 0);
    chk("t6_rst_o_last", bus.o_last, 0);
    chk("t6_rst_o_len", bus.o_len, 0);
    idle(2);
    rst_n = 1'b1;
    send_pkt(3, 32'h7000, -1);
    @(negedge clk);
    chk("t6_fresh_first", bus.o_stream, 32'h7000);
    chk("t6_fresh_len", bus.o_len, 2);
    idle(6);
    chk("t6_drained", bus.pkt_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
